// File: rtl/inv_pipe_pkg.sv
// Shared constants and helpers for the inv_pipe inverting register pipeline.
package inv_pipe_pkg;

    localparam int WidthMin = 1;
    localparam int WidthMax = 64;
    localparam int DepthMin = 1;
    localparam int DepthMax = 16;

    localparam logic [63:0] ResetValDefault = 64'h0;

    // Level must hold 0..depth inclusive, hence depth+1 distinct values.
    function automatic int levelWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/inv_pipe_stage.sv
// One pipeline register stage: a valid bit plus an opaque payload (data, and parity when carried).
module inv_pipe_stage #(
    parameter int               PAY_W     = 8,
    parameter logic [PAY_W-1:0] RESET_VAL = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             Enable,
    input  logic             ValidIn,
    input  logic [PAY_W-1:0] PayIn,
    output logic             ValidOut,
    output logic [PAY_W-1:0] PayOut
);

    always_ff @(posedge Clock) begin
        // NOTE: non-blocking so every stage captures its predecessor's pre-edge value, giving a true shift.
        if (Reset || Flush) begin
            ValidOut <= 1'b0;
            // NOTE: data is reset as well as valid, because DataOut must read RESET_VAL after reset or flush.
            PayOut   <= RESET_VAL;
        end else if (Enable) begin
            ValidOut <= ValidIn;
            PayOut   <= PayIn;
        end
    end

endmodule

// File: rtl/inv_pipe.sv
// Inverting register pipeline: entry XOR with INV_MASK, DEPTH stages, Level counter.
// Optional build macro INV_PIPE_PARITY_EN adds a carried even-parity bit and the ParityErr check.
module inv_pipe
    import inv_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] INV_MASK  = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(ResetValDefault)
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Enable,
    input  logic                          Flush,
    input  logic                          ValidIn,
    input  logic [WIDTH-1:0]              DataIn,
    output logic                          ValidOut,
    output logic [WIDTH-1:0]              DataOut,
    output logic [levelWidth(DEPTH)-1:0]  Level,
    output logic                          ParityErr
);

    localparam int LevelW = levelWidth(DEPTH);

`ifdef INV_PIPE_PARITY_EN
    localparam int               ParW     = 1;
    localparam logic [WIDTH:0]   PayReset = {^RESET_VAL, RESET_VAL};
`else
    localparam int               ParW     = 0;
    localparam logic [WIDTH-1:0] PayReset = RESET_VAL;
`endif
    localparam int PayW = WIDTH + ParW;

    if (WIDTH < WidthMin || WIDTH > WidthMax || DEPTH < DepthMin || DEPTH > DepthMax) begin : genBadParam
        $error("inv_pipe: WIDTH or DEPTH outside supported range");
    end

    // Chain index 0 is the transformed entry word; index k+1 is the output of stage k.
    logic             validChain [0:DEPTH];
    logic [PayW-1:0]  payChain   [0:DEPTH];
    logic [WIDTH-1:0] dataEntry;
    logic [LevelW-1:0] levelNext;

    assign dataEntry = DataIn ^ INV_MASK;
    assign validChain[0] = ValidIn;

`ifdef INV_PIPE_PARITY_EN
    assign payChain[0] = {^dataEntry, dataEntry};
`else
    assign payChain[0] = dataEntry;
`endif

    for (genvar k = 0; k < DEPTH; k++) begin : genStage
        inv_pipe_stage #(
            .PAY_W     (PayW),
            .RESET_VAL (PayReset)
        ) uStage (
            .Clock    (Clock),
            .Reset    (Reset),
            .Flush    (Flush),
            .Enable   (Enable),
            .ValidIn  (validChain[k]),
            .PayIn    (payChain[k]),
            .ValidOut (validChain[k+1]),
            .PayOut   (payChain[k+1])
        );
    end

    assign ValidOut = validChain[DEPTH];
    assign DataOut  = payChain[DEPTH][WIDTH-1:0];

    always_comb begin
        // NOTE: default assigned first so no path leaves levelNext unassigned and no latch is inferred.
        levelNext = Level;
        if (Enable) begin
            levelNext = Level + LevelW'(ValidIn) - LevelW'(ValidOut);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset || Flush) begin
            Level <= '0;
        end else begin
            Level <= levelNext;
        end
    end

`ifdef INV_PIPE_PARITY_EN
    // Checked on the word entering the last stage so the flag lines up with that word on ValidOut.
    always_ff @(posedge Clock) begin
        if (Reset || Flush) begin
            ParityErr <= 1'b0;
        end else if (Enable) begin
            ParityErr <= validChain[DEPTH-1] &&
                         ((^payChain[DEPTH-1][WIDTH-1:0]) != payChain[DEPTH-1][WIDTH]);
        end
    end
`else
    assign ParityErr = 1'b0;
`endif

    levelInRange: assert property (@(posedge Clock) disable iff (Reset) Level <= LevelW'(DEPTH));

endmodule

// File: tb/tb_inv_pipe.sv
// Directed self-checking bench for inv_pipe at WIDTH=8, DEPTH=3, all-ones invert mask.
module tb_inv_pipe;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Enable;
    logic       Flush;
    logic       ValidIn;
    logic [7:0] DataIn;
    logic       ValidOut;
    logic [7:0] DataOut;
    logic [1:0] Level;
    logic       ParityErr;

    int nChecks = 0;
    int nPass   = 0;

    inv_pipe #(
        .WIDTH (8),
        .DEPTH (3)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Enable    (Enable),
        .Flush     (Flush),
        .ValidIn   (ValidIn),
        .DataIn    (DataIn),
        .ValidOut  (ValidOut),
        .DataOut   (DataOut),
        .Level     (Level),
        .ParityErr (ParityErr)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive inputs just after an edge, then advance to 1 time unit past the next rising edge.
    task automatic tick(input logic en, input logic fl, input logic vi, input logic [7:0] di);
        Enable  = en;
        Flush   = fl;
        ValidIn = vi;
        DataIn  = di;
        @(posedge Clock);
        #1;
    endtask

    task automatic expectOut(input string tag, input logic vo, input logic [7:0] dout, input logic [1:0] lvl);
        check({tag, ".valid"}, ValidOut, vo);
        if (vo) check({tag, ".data"}, DataOut, dout);
        check({tag, ".level"}, Level, lvl);
        check({tag, ".perr"}, ParityErr, 1'b0);
    endtask

    initial begin
        Reset = 1'b1;
        Enable = 1'b0; Flush = 1'b0; ValidIn = 1'b0; DataIn = 8'h00;

        // Reset held for two edges with random inputs.
        for (int i = 0; i < 2; i++) begin
            tick(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            check("reset.valid", ValidOut, 1'b0);
            check("reset.data", DataOut, 8'h00);
            check("reset.level", Level, 2'd0);
            check("reset.perr", ParityErr, 1'b0);
        end
        Reset = 1'b0;

        // Fill: 0x5A emerges inverted after the third enabled edge.
        tick(1'b1, 1'b0, 1'b1, 8'h5A);
        expectOut("fill1", 1'b0, 8'h00, 2'd1);
        tick(1'b1, 1'b0, 1'b1, 8'h11);
        expectOut("fill2", 1'b0, 8'h00, 2'd2);
        tick(1'b1, 1'b0, 1'b1, 8'h22);
        expectOut("fill3", 1'b1, 8'hA5, 2'd3);

        // Stall with ValidIn asserted: nothing moves, nothing captured.
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 1'b1, 8'h77);
            expectOut("stall", 1'b1, 8'hA5, 2'd3);
        end

        // Drain: remaining words, then an invalid transformed 0x00 reaches the output.
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        expectOut("drain1", 1'b1, 8'hEE, 2'd2);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        expectOut("drain2", 1'b1, 8'hDD, 2'd1);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        expectOut("drain3", 1'b0, 8'h00, 2'd0);
        check("drain3.data", DataOut, 8'hFF);

        // Streaming 0x00..0x0F back to back, then three idle cycles.
        for (int i = 1; i <= 19; i++) begin
            logic [7:0] expData;
            logic [1:0] expLvl;
            logic       expValid;
            expData  = ~8'(i - 3);
            expValid = (i >= 3) && (i <= 18);
            if (i <= 16) expLvl = (i < 3) ? 2'(i) : 2'd3;
            else         expLvl = 2'(19 - i);
            if (i <= 16) tick(1'b1, 1'b0, 1'b1, 8'(i - 1));
            else         tick(1'b1, 1'b0, 1'b0, 8'h00);
            expectOut("stream", expValid, expData, expLvl);
        end

        // Flush with Enable and a valid incoming word.
        tick(1'b1, 1'b0, 1'b1, 8'h10);
        tick(1'b1, 1'b0, 1'b1, 8'h20);
        tick(1'b1, 1'b0, 1'b1, 8'h30);
        expectOut("preflush", 1'b1, 8'hEF, 2'd3);
        tick(1'b1, 1'b1, 1'b1, 8'h99);
        expectOut("flush", 1'b0, 8'h00, 2'd0);
        check("flush.data", DataOut, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h00);
            expectOut("postflush", 1'b0, 8'h00, 2'd0);
        end

        // Reset mid-stream discards in-flight words; the next word still takes three edges.
        tick(1'b1, 1'b0, 1'b1, 8'h01);
        tick(1'b1, 1'b0, 1'b1, 8'h02);
        Reset = 1'b1;
        tick(1'b1, 1'b0, 1'b1, 8'h03);
        expectOut("midreset", 1'b0, 8'h00, 2'd0);
        check("midreset.data", DataOut, 8'h00);
        Reset = 1'b0;
        tick(1'b1, 1'b0, 1'b1, 8'hC3);
        expectOut("after1", 1'b0, 8'h00, 2'd1);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        expectOut("after2", 1'b0, 8'h00, 2'd1);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        expectOut("after3", 1'b1, 8'h3C, 2'd1);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        expectOut("after4", 1'b0, 8'h00, 2'd0);

`ifdef INV_PIPE_PARITY_EN
        // Corrupt the word held in stage 1 for one edge; only that word raises ParityErr.
        tick(1'b1, 1'b0, 1'b1, 8'h0F);
        tick(1'b1, 1'b0, 1'b1, 8'h33);
        force dut.payChain[2] = {1'b0, 8'hF1};
        tick(1'b1, 1'b0, 1'b1, 8'h44);
        release dut.payChain[2];
        check("parity.flip.valid", ValidOut, 1'b1);
        check("parity.flip.err", ParityErr, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        check("parity.clean.data", DataOut, 8'hCC);
        check("parity.clean.err", ParityErr, 1'b0);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
